// File: rtl/answer_arb_pkg.sv
// Shared constants, state encoding and width helpers
// for the answer-select arbiter and its round-robin picker.
package answer_arb_pkg;

  localparam int NUM_BTN_DEF = 4;
  localparam int LOCKOUT_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OFFER   = 2'd1,
    S_LOCKOUT = 2'd2
  } state_t;

  function automatic int idxw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cntw(input int l);
    return (l < 1) ? 1 : $clog2(l + 1);
  endfunction

endpackage

// File: rtl/answer_select_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest set index
// at or above rr_ptr, wrapping back to 0.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] pending,
  input  logic [W-1:0] rr_ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  int j;

  // Walk offsets from farthest to nearest so the nearest wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % N;
      if (pending[j]) begin
        found = 1'b1;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/answer_select_arbiter.sv
// Serializes answer-button presses into one offered choice at a time.
// Optional DROP_COUNT_EN adds a saturating dropped-press counter.
module answer_select_arbiter
  import answer_arb_pkg::*;
#(
  parameter  int NUM_BTN        = NUM_BTN_DEF,
  parameter  int LOCKOUT_CYCLES = LOCKOUT_DEF,
  localparam int IDXW           = idxw(NUM_BTN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_pulse,
  input  logic               enable,
  input  logic               sel_ack,
  output logic               sel_valid,
  output logic [IDXW-1:0]    sel_index,
  output logic               busy
`ifdef DROP_COUNT_EN
  ,
  output logic [7:0]         drop_count
`endif
);

  localparam int CW = cntw(LOCKOUT_CYCLES);
  localparam logic [CW-1:0] LOCK_LOAD =
    (LOCKOUT_CYCLES > 0) ? CW'(LOCKOUT_CYCLES - 1) : '0;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_BTN - 1);

  state_t             state;
  state_t             state_nx;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] pend_nx;
  logic [NUM_BTN-1:0] clr;
  logic [IDXW-1:0]    rr_ptr;
  logic [IDXW-1:0]    ptr_nx;
  logic [IDXW-1:0]    idx_nx;
  logic [IDXW-1:0]    pick_idx;
  logic               found;
  logic [CW-1:0]      lock_cnt;
  logic [CW-1:0]      lock_nx;

  rr_pick #(
    .N (NUM_BTN),
    .W (IDXW)
  ) u_pick (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .found   (found),
    .idx     (pick_idx)
  );

  always_comb begin
    state_nx = state;
    clr      = '0;
    idx_nx   = sel_index;
    ptr_nx   = rr_ptr;
    lock_nx  = lock_cnt;
    unique case (state)
      S_IDLE: begin
        if (found) begin
          state_nx = S_OFFER;
          idx_nx   = pick_idx;
          clr      = NUM_BTN'(1) << pick_idx;
        end
      end
      S_OFFER: begin
        if (sel_ack) begin
          ptr_nx = (sel_index == LAST_IDX) ?
                   '0 : sel_index + 1'b1;
          if (LOCKOUT_CYCLES == 0) begin
            state_nx = S_IDLE;
          end else begin
            state_nx = S_LOCKOUT;
            lock_nx  = LOCK_LOAD;
          end
        end
      end
      S_LOCKOUT: begin
        if (lock_cnt == '0) begin
          state_nx = S_IDLE;
        end else begin
          lock_nx = lock_cnt - 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    // New pulses win over the grant clear on the same bit.
    pend_nx = enable ? ((pending & ~clr) | btn_pulse) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      pending   <= '0;
      rr_ptr    <= '0;
      lock_cnt  <= '0;
      sel_valid <= 1'b0;
      sel_index <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      pending   <= pend_nx;
      rr_ptr    <= ptr_nx;
      lock_cnt  <= lock_nx;
      sel_valid <= (state_nx == S_OFFER);
      sel_index <= idx_nx;
      busy      <= (state_nx != S_IDLE);
    end
  end

`ifdef DROP_COUNT_EN
  logic drop_hit;

  assign drop_hit = enable & (|(btn_pulse & pending));

  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (drop_hit && drop_count != 8'hFF) begin
      drop_count <= drop_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_answer_select_arbiter.sv
// Randomized and directed bench for answer_select_arbiter
// against a behavioural model of the arbitration rules.
module tb_answer_select_arbiter;

  localparam int N = 4;
  localparam int L = 16;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] btn_pulse = '0;
  logic         enable = 1'b0;
  logic         sel_ack = 1'b0;
  logic         sel_valid;
  logic [W-1:0] sel_index;
  logic         busy;
`ifdef DROP_COUNT_EN
  logic [7:0]   drop_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  bit m_pend [N];
  bit m_offer;
  int m_idx;
  int m_ptr;
  int m_lock;
  int m_drop;

  always #5 clk = ~clk;

  answer_select_arbiter #(
    .NUM_BTN        (N),
    .LOCKOUT_CYCLES (L)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_pulse  (btn_pulse),
    .enable     (enable),
    .sel_ack    (sel_ack),
    .sel_valid  (sel_valid),
    .sel_index  (sel_index),
    .busy       (busy)
`ifdef DROP_COUNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  function automatic void model_step(input bit r,
                                     input logic [N-1:0] p,
                                     input bit en,
                                     input bit ack);
    int g;
    bit hit;
    g = -1;
    hit = 1'b0;
    if (!r) begin
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_offer = 1'b0;
      m_idx = 0;
      m_ptr = 0;
      m_lock = 0;
      m_drop = 0;
      return;
    end
    for (int i = 0; i < N; i++)
      if (p[i] && m_pend[i]) hit = 1'b1;
    if (en && hit && m_drop < 255) m_drop++;
    if (m_offer) begin
      if (ack) begin
        m_ptr = (m_idx + 1) % N;
        m_offer = 1'b0;
        m_lock = L;
      end
    end else if (m_lock > 0) begin
      m_lock--;
    end else begin
      for (int k = 0; k < N; k++)
        if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      if (g >= 0) begin
        m_offer = 1'b1;
        m_idx = g;
      end
    end
    for (int i = 0; i < N; i++)
      m_pend[i] = en && (p[i] || (m_pend[i] && i != g));
  endfunction

  task automatic tick(input bit r, input logic [N-1:0] p,
                      input bit en, input bit ack);
    reset = r;
    btn_pulse = p;
    enable = en;
    sel_ack = ack;
    @(posedge clk);
    model_step(r, p, en, ack);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b0, '0, 1'b1, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0);
    tick(1'b1, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    tick(1'b0, '0, 1'b1, 1'b1);
    tick(1'b0, 4'b1111, 1'b1, 1'b1);
    n_cmp++;
    if (sel_valid !== 1'b0 || sel_index !== 2'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: valid=%b idx=%0d busy=%b want 0 0 0",
               sel_valid, sel_index, busy);
    end
`ifdef DROP_COUNT_EN
    n_cmp++;
    if (drop_count !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_drop: got %0d want 0", drop_count);
    end
`endif
    tick(1'b1, '0, 1'b1, 1'b0);
  endtask

  task automatic test_latency();
    do_reset();
    tick(1'b1, 4'b0100, 1'b1, 1'b0);
    n_cmp++;
    if (sel_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL latency_early: valid=%b want 0", sel_valid);
    end
    tick(1'b1, '0, 1'b1, 1'b0);
    n_cmp++;
    if (sel_valid !== 1'b1 || sel_index !== 2'd2 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL latency_offer: valid=%b idx=%0d busy=%b want 1 2 1",
               sel_valid, sel_index, busy);
    end
    for (int c = 0; c < 5; c++) begin
      tick(1'b1, '0, 1'b1, 1'b0);
      n_cmp++;
      if (sel_valid !== 1'b1 || sel_index !== 2'd2) begin
        n_bad++;
        $display("FAIL hold_stable: cyc %0d valid=%b idx=%0d want 1 2",
                 c, sel_valid, sel_index);
      end
    end
    tick(1'b1, '0, 1'b1, 1'b1);
    n_cmp++;
    if (sel_valid !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL ack_drop: valid=%b busy=%b want 0 1",
               sel_valid, busy);
    end
  endtask

  task automatic wait_offer(input string nm, input int want_idx);
    int c;
    c = 0;
    while (!sel_valid && c < 100) begin
      tick(1'b1, '0, 1'b1, 1'b0);
      c++;
    end
    n_cmp++;
    if (c != L + 1 || sel_index !== W'(want_idx)) begin
      n_bad++;
      $display("FAIL %s: edges_after_ack=%0d idx=%0d want %0d %0d",
               nm, c + 1, sel_index, L + 2, want_idx);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    tick(1'b1, 4'b1010, 1'b1, 1'b0);
    tick(1'b1, '0, 1'b1, 1'b0);
    n_cmp++;
    if (sel_valid !== 1'b1 || sel_index !== 2'd1) begin
      n_bad++;
      $display("FAIL rr_first: valid=%b idx=%0d want 1 1",
               sel_valid, sel_index);
    end
    tick(1'b1, '0, 1'b1, 1'b1);
    wait_offer("rr_second", 3);
    tick(1'b1, 4'b0101, 1'b1, 1'b1);
    wait_offer("rr_wrap_first", 0);
    tick(1'b1, '0, 1'b1, 1'b1);
    wait_offer("rr_wrap_second", 2);
    tick(1'b1, '0, 1'b1, 1'b1);
  endtask

  task automatic test_enable_clear();
    int offers;
    offers = 0;
    do_reset();
    tick(1'b1, 4'b0100, 1'b1, 1'b0);
    tick(1'b1, 4'b0011, 1'b1, 1'b0);
    tick(1'b1, '0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) tick(1'b1, '0, 1'b1, 1'b0);
    n_cmp++;
    if (sel_valid !== 1'b1 || sel_index !== 2'd2) begin
      n_bad++;
      $display("FAIL en_keep_offer: valid=%b idx=%0d want 1 2",
               sel_valid, sel_index);
    end
    tick(1'b1, '0, 1'b1, 1'b1);
    for (int c = 0; c < L + 8; c++) begin
      tick(1'b1, '0, 1'b1, 1'b0);
      if (sel_valid) offers++;
    end
    n_cmp++;
    if (offers != 0) begin
      n_bad++;
      $display("FAIL en_cleared: offer_cycles=%0d want 0", offers);
    end
  endtask

  task automatic test_drop();
    int offers;
    int last;
    bit prev;
    bit ack;
    offers = 0;
    last = -1;
    prev = 1'b0;
    do_reset();
    tick(1'b1, 4'b0001, 1'b1, 1'b0);
    tick(1'b1, '0, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) tick(1'b1, 4'b0010, 1'b1, 1'b0);
`ifdef DROP_COUNT_EN
    n_cmp++;
    if (drop_count !== 8'd3) begin
      n_bad++;
      $display("FAIL drop_count: got %0d want 3", drop_count);
    end
`endif
    tick(1'b1, '0, 1'b1, 1'b1);
    for (int c = 0; c < 3 * L; c++) begin
      ack = sel_valid;
      tick(1'b1, '0, 1'b1, ack);
      if (sel_valid && !prev) begin
        offers++;
        last = int'(sel_index);
      end
      prev = sel_valid;
    end
    n_cmp++;
    if (offers != 1 || last != 1) begin
      n_bad++;
      $display("FAIL drop_merge: offers=%0d idx=%0d want 1 1",
               offers, last);
    end
  endtask

  task automatic test_reset_lockout();
    int offers;
    offers = 0;
    do_reset();
    tick(1'b1, 4'b1000, 1'b1, 1'b0);
    tick(1'b1, '0, 1'b1, 1'b0);
    tick(1'b1, '0, 1'b1, 1'b1);
    tick(1'b1, 4'b0001, 1'b1, 1'b0);
    tick(1'b1, '0, 1'b1, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (sel_valid !== 1'b0 || sel_index !== 2'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_lockout: valid=%b idx=%0d busy=%b want 0 0 0",
               sel_valid, sel_index, busy);
    end
    for (int c = 0; c < L + 8; c++) begin
      tick(1'b1, '0, 1'b1, 1'b0);
      if (sel_valid) offers++;
    end
    n_cmp++;
    if (offers != 0) begin
      n_bad++;
      $display("FAIL rst_no_offer: offer_cycles=%0d want 0", offers);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] p;
    bit en;
    bit ack;
    bit r;
    for (int c = 0; c < 3000; c++) begin
      p = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      en = ($urandom_range(0, 15) != 0);
      ack = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 299) != 0);
      tick(r, p, en, ack);
      n_cmp++;
      if (sel_valid !== m_offer || sel_index !== W'(m_idx) ||
          busy !== (m_offer || m_lock > 0)) begin
        n_bad++;
        $display("FAIL rand_out: cyc %0d v/i/b=%b/%0d/%b want %b/%0d/%b",
                 c, sel_valid, sel_index, busy,
                 m_offer, m_idx, (m_offer || m_lock > 0));
      end
`ifdef DROP_COUNT_EN
      n_cmp++;
      if (drop_count !== 8'(m_drop)) begin
        n_bad++;
        $display("FAIL rand_drop: cyc %0d got %0d want %0d",
                 c, drop_count, m_drop);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_round_robin();
    test_enable_clear();
    test_drop();
    test_reset_lockout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
